// File: rtl/ram_matrix.sv
// ram_matrix: LINES x COLUMNS word store addressed by line/column.
// Registered read with a valid pulse, a write port and out-of-range detection.
// A wipe request runs a row-major sweep that zeroes one cell per cycle while busy is high.
module ram_matrix #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LINES   = 3,
    parameter int unsigned COLUMNS = 3,
    parameter int unsigned LINE_W  = 2,
    parameter int unsigned COL_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_clear_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_wipe,
    input  logic [LINE_W-1:0] i_addr_line,
    input  logic [COL_W-1:0]  i_addr_column,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_q_valid,
    output logic              o_addr_err,
    output logic              o_busy
);

    typedef enum logic {StIdle, StWipe} state_t;

    // Storage is never reset; only the wipe sweep clears it.
    logic [WIDTH-1:0] r_mem [LINES][COLUMNS];

    state_t             r_state;
    logic [LINE_W-1:0]  r_wipe_line;
    logic [COL_W-1:0]   r_wipe_col;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_valid;
    logic               r_addr_err;

    state_t             w_state_nxt;
    logic [LINE_W-1:0]  w_wipe_line_nxt;
    logic [COL_W-1:0]   w_wipe_col_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_q_valid_nxt;
    logic               w_addr_err_nxt;
    logic               w_mem_we;
    logic [LINE_W-1:0]  w_mem_line;
    logic [COL_W-1:0]   w_mem_col;
    logic [WIDTH-1:0]   w_mem_data;
    logic               w_in_range;
    logic               w_last_col;
    logic               w_last_line;

    // Compare at 32 bits so a fully populated address space still decodes correctly.
    always_comb begin
        w_in_range  = (32'(i_addr_line) < LINES) && (32'(i_addr_column) < COLUMNS);
        w_last_col  = (32'(r_wipe_col) == COLUMNS - 1);
        w_last_line = (32'(r_wipe_line) == LINES - 1);
    end

    // Next-state, sweep counters, memory write port and registered-output next values.
    always_comb begin
        w_state_nxt     = r_state;
        w_wipe_line_nxt = r_wipe_line;
        w_wipe_col_nxt  = r_wipe_col;
        w_q_nxt         = r_q;
        w_q_valid_nxt   = 1'b0;
        w_addr_err_nxt  = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_line      = i_addr_line;
        w_mem_col       = i_addr_column;
        w_mem_data      = i_data;
        unique case (r_state)
            StIdle: begin
                if (i_wipe) begin
                    // Accesses presented together with the wipe request are dropped.
                    w_state_nxt     = StWipe;
                    w_wipe_line_nxt = '0;
                    w_wipe_col_nxt  = '0;
                end else begin
                    w_mem_we       = i_we && w_in_range;
                    w_addr_err_nxt = (i_we || i_re) && !w_in_range;
                    if (i_re) begin
                        w_q_valid_nxt = 1'b1;
                        // Read sees the pre-write word when we/re hit the same cell.
                        w_q_nxt = w_in_range ? r_mem[i_addr_line][i_addr_column] : '0;
                    end
                end
            end
            StWipe: begin
                w_mem_we   = 1'b1;
                w_mem_line = r_wipe_line;
                w_mem_col  = r_wipe_col;
                w_mem_data = '0;
                if (w_last_col) begin
                    w_wipe_col_nxt = '0;
                    if (w_last_line) begin
                        w_wipe_line_nxt = '0;
                        w_state_nxt     = StIdle;
                    end else begin
                        w_wipe_line_nxt = r_wipe_line + LINE_W'(1);
                    end
                end else begin
                    w_wipe_col_nxt = r_wipe_col + COL_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM, sweep counters and read outputs; reset aborts a wipe in progress.
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state     <= StIdle;
            r_wipe_line <= '0;
            r_wipe_col  <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wipe_line <= w_wipe_line_nxt;
            r_wipe_col  <= w_wipe_col_nxt;
            r_q         <= w_q_nxt;
            r_q_valid   <= w_q_valid_nxt;
            r_addr_err  <= w_addr_err_nxt;
        end
    end

    // Array write port shared by normal writes and the wipe sweep.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_line][w_mem_col] <= w_mem_data;
        end
    end

    // Busy is a pure decode of the registered state.
    always_comb begin
        o_q        = r_q;
        o_q_valid  = r_q_valid;
        o_addr_err = r_addr_err;
        o_busy     = (r_state == StWipe);
    end

endmodule

// File: tb/tb_ram_matrix.sv
// Directed bench for ram_matrix: default 3x3x16 instance plus a 6x9x8 instance.
module tb_ram_matrix;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;

    // Default instance signals
    logic        we = 0, re = 0, wipe = 0;
    logic [1:0]  aline = 0, acol = 0;
    logic [15:0] data = 0;
    logic [15:0] q;
    logic        q_valid, addr_err, busy;

    // Large instance signals
    logic        we6 = 0, re6 = 0, wipe6 = 0;
    logic [2:0]  aline6 = 0;
    logic [3:0]  acol6 = 0;
    logic [7:0]  data6 = 0;
    logic [7:0]  q6;
    logic        q_valid6, addr_err6, busy6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_matrix dut (
        .i_clk(clk), .i_clear_n(clear_n), .i_we(we), .i_re(re), .i_wipe(wipe),
        .i_addr_line(aline), .i_addr_column(acol), .i_data(data),
        .o_q(q), .o_q_valid(q_valid), .o_addr_err(addr_err), .o_busy(busy)
    );

    ram_matrix #(.WIDTH(8), .LINES(6), .COLUMNS(9), .LINE_W(3), .COL_W(4)) dut6 (
        .i_clk(clk), .i_clear_n(clear_n), .i_we(we6), .i_re(re6), .i_wipe(wipe6),
        .i_addr_line(aline6), .i_addr_column(acol6), .i_data(data6),
        .o_q(q6), .o_q_valid(q_valid6), .o_addr_err(addr_err6), .o_busy(busy6)
    );

    // Advance one edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input int c, input logic [15:0] d);
        aline = 2'(l); acol = 2'(c); data = d; we = 1;
        cyc();
        we = 0;
    endtask

    task automatic rd(input int l, input int c);
        aline = 2'(l); acol = 2'(c); re = 1;
        cyc();
        re = 0;
    endtask

    task automatic wr6(input int l, input int c, input logic [7:0] d);
        aline6 = 3'(l); acol6 = 4'(c); data6 = d; we6 = 1;
        cyc();
        we6 = 0;
    endtask

    task automatic rd6(input int l, input int c);
        aline6 = 3'(l); acol6 = 4'(c); re6 = 1;
        cyc();
        re6 = 0;
    endtask

    task automatic test_reset();
        clear_n = 0;
        #3;
        n_tests++;
        if ({q, q_valid, addr_err, busy} !== 19'd0) begin
            $display("FAIL reset_a: got q=%h v=%b e=%b b=%b, want all 0", q, q_valid, addr_err, busy);
            n_fail++;
        end
        n_tests++;
        if ({q6, q_valid6, addr_err6, busy6} !== 11'd0) begin
            $display("FAIL reset_b: got q=%h v=%b e=%b b=%b, want all 0",
                     q6, q_valid6, addr_err6, busy6);
            n_fail++;
        end
        @(negedge clk);
        clear_n = 1;
        cyc();
    endtask

    task automatic test_basic();
        wr(0, 0, 16'hAAAA);
        wr(2, 2, 16'h3333);
        rd(0, 0);
        n_tests++;
        if (q !== 16'hAAAA || q_valid !== 1'b1) begin
            $display("FAIL basic_rd00: got q=%h v=%b, want AAAA 1", q, q_valid);
            n_fail++;
        end
        cyc();
        n_tests++;
        if (q !== 16'hAAAA || q_valid !== 1'b0) begin
            $display("FAIL basic_hold: got q=%h v=%b, want AAAA 0", q, q_valid);
            n_fail++;
        end
        rd(2, 2);
        n_tests++;
        if (q !== 16'h3333 || q_valid !== 1'b1 || addr_err !== 1'b0) begin
            $display("FAIL basic_rd22: got q=%h v=%b e=%b, want 3333 1 0", q, q_valid, addr_err);
            n_fail++;
        end
    endtask

    task automatic test_read_before_write();
        wr(1, 1, 16'hEEEE);
        aline = 1; acol = 1; data = 16'h1234; we = 1; re = 1;
        cyc();
        we = 0; re = 0;
        n_tests++;
        if (q !== 16'hEEEE || q_valid !== 1'b1) begin
            $display("FAIL rbw_old: got q=%h v=%b, want EEEE 1", q, q_valid);
            n_fail++;
        end
        rd(1, 1);
        n_tests++;
        if (q !== 16'h1234) begin
            $display("FAIL rbw_new: got q=%h, want 1234", q);
            n_fail++;
        end
    endtask

    task automatic test_addr_err();
        wr(1, 0, 16'h1010);
        rd(3, 0);
        n_tests++;
        if (q !== 16'h0 || q_valid !== 1'b1 || addr_err !== 1'b1) begin
            $display("FAIL oor_read: got q=%h v=%b e=%b, want 0 1 1", q, q_valid, addr_err);
            n_fail++;
        end
        cyc();
        n_tests++;
        if (addr_err !== 1'b0) begin
            $display("FAIL oor_pulse: got e=%b, want 0", addr_err);
            n_fail++;
        end
        wr(0, 3, 16'h5555);
        n_tests++;
        if (addr_err !== 1'b1 || q_valid !== 1'b0) begin
            $display("FAIL oor_write: got e=%b v=%b, want 1 0", addr_err, q_valid);
            n_fail++;
        end
        rd(0, 0);
        n_tests++;
        if (q !== 16'hAAAA) begin
            $display("FAIL oor_cell00: got q=%h, want AAAA", q);
            n_fail++;
        end
        rd(1, 0);
        n_tests++;
        if (q !== 16'h1010) begin
            $display("FAIL oor_alias10: got q=%h, want 1010", q);
            n_fail++;
        end
    endtask

    task automatic test_wipe();
        int n;
        for (int k = 0; k < 9; k++) wr(k / 3, k % 3, 16'h1111 * 16'(k + 1));
        wipe = 1;
        cyc();
        // Hold every request during the sweep; all of it must be ignored.
        aline = 0; acol = 0; data = 16'hFFFF; we = 1; re = 1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n_tests++;
            if (q_valid !== 1'b0 || addr_err !== 1'b0) begin
                $display("FAIL wipe_quiet: got v=%b e=%b at busy cycle %0d, want 0 0",
                         q_valid, addr_err, n);
                n_fail++;
            end
            n++;
            cyc();
        end
        we = 0; re = 0; wipe = 0;
        n_tests++;
        if (n !== 9) begin
            $display("FAIL wipe_len: got %0d busy cycles, want 9", n);
            n_fail++;
        end
        for (int k = 0; k < 9; k++) begin
            rd(k / 3, k % 3);
            n_tests++;
            if (q !== 16'h0 || q_valid !== 1'b1) begin
                $display("FAIL wipe_cell%0d: got q=%h v=%b, want 0000 1", k, q, q_valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_wipe_abort();
        for (int k = 0; k < 9; k++) wr(k / 3, k % 3, 16'hC000 + 16'(k));
        wipe = 1;
        cyc();
        wipe = 0;
        repeat (4) cyc();
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy_before: got b=%b, want 1", busy);
            n_fail++;
        end
        clear_n = 0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            $display("FAIL abort_busy_now: got b=%b, want 0", busy);
            n_fail++;
        end
        @(negedge clk);
        clear_n = 1;
        cyc();
        for (int k = 0; k < 9; k++) begin
            rd(k / 3, k % 3);
            n_tests++;
            if (q !== ((k < 4) ? 16'h0 : 16'hC000 + 16'(k))) begin
                $display("FAIL abort_cell%0d: got q=%h, want %h", k, q,
                         (k < 4) ? 16'h0 : 16'hC000 + 16'(k));
                n_fail++;
            end
        end
    endtask

    task automatic test_params();
        int n;
        wr6(5, 8, 8'hA5);
        wr6(0, 0, 8'h3C);
        rd6(5, 8);
        n_tests++;
        if (q6 !== 8'hA5 || q_valid6 !== 1'b1 || addr_err6 !== 1'b0) begin
            $display("FAIL p_corner: got q=%h v=%b e=%b, want A5 1 0", q6, q_valid6, addr_err6);
            n_fail++;
        end
        rd6(6, 0);
        n_tests++;
        if (q6 !== 8'h0 || addr_err6 !== 1'b1) begin
            $display("FAIL p_oor_line: got q=%h e=%b, want 00 1", q6, addr_err6);
            n_fail++;
        end
        wr6(0, 9, 8'hFF);
        n_tests++;
        if (addr_err6 !== 1'b1) begin
            $display("FAIL p_oor_col: got e=%b, want 1", addr_err6);
            n_fail++;
        end
        rd6(0, 0);
        n_tests++;
        if (q6 !== 8'h3C) begin
            $display("FAIL p_cell00: got q=%h, want 3C", q6);
            n_fail++;
        end
        wipe6 = 1;
        cyc();
        wipe6 = 0;
        n = 0;
        while (busy6 === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        n_tests++;
        if (n !== 54) begin
            $display("FAIL p_wipe_len: got %0d busy cycles, want 54", n);
            n_fail++;
        end
        rd6(5, 8);
        n_tests++;
        if (q6 !== 8'h0) begin
            $display("FAIL p_wiped_corner: got q=%h, want 00", q6);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_before_write();
        test_addr_err();
        test_wipe();
        test_wipe_abort();
        test_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
